// File: rtl/seg_scan_mux_pkg.sv
// Shared constants for the scanned 7-segment display blocks.
package seg_scan_mux_pkg;

  localparam int unsigned SEL_W               = 2;
  localparam int unsigned REFRESH_DIV_DEFAULT = 50000;
  localparam logic [3:0]  AN_OFF              = 4'b1111;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_LAST = sel_t'(3);

endpackage

// File: rtl/seg_scan_mux_refresh_prescaler.sv
// Free-running prescaler: tick is high on the last cycle of each REFRESH_DIV-cycle slot.
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed scanner with frame-aligned double-buffered commit
// and leading-zero blanking; feeds an external hex-to-7-segment decoder.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic        pending,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start
);

  logic        tick;
  logic        commit;
  logic        blanked;
  logic [3:0]  lz_zero;

  sel_t        sel_q, sel_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic        pend_q, pend_d;
  logic        frame_start_q, frame_start_d;
  logic        blank_lz_q, blank_lz_d;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Commit reads the pre-edge shadow, so a load on the same edge survives as pending.
  always_comb begin
    commit        = tick && (sel_q == SEL_LAST) && pend_q;
    sel_d         = tick ? sel_q + 1'b1 : sel_q;
    frame_start_d = tick && (sel_q == SEL_LAST);
    shadow_d      = load ? value : shadow_q;
    shadow_dp_d   = load ? dp_in : shadow_dp_q;
    disp_d        = commit ? shadow_q : disp_q;
    disp_dp_d     = commit ? shadow_dp_q : disp_dp_q;
    pend_d        = load ? 1'b1 : (commit ? 1'b0 : pend_q);
    blank_lz_d    = blank_lz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q         <= '0;
      shadow_q      <= '0;
      shadow_dp_q   <= '0;
      disp_q        <= '0;
      disp_dp_q     <= '0;
      pend_q        <= 1'b0;
      frame_start_q <= 1'b0;
      blank_lz_q    <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      shadow_dp_q   <= shadow_dp_d;
      disp_q        <= disp_d;
      disp_dp_q     <= disp_dp_d;
      pend_q        <= pend_d;
      frame_start_q <= frame_start_d;
      blank_lz_q    <= blank_lz_d;
    end
  end

  // blank_lz is registered so every output derives from flops only.
  always_comb begin
    lz_zero[0]  = 1'b0;
    lz_zero[1]  = (disp_q[15:4] == '0);
    lz_zero[2]  = (disp_q[15:8] == '0);
    lz_zero[3]  = (disp_q[15:12] == '0);
    blanked     = blank_lz_q && lz_zero[sel_q];
    digit       = 4'(disp_q >> {sel_q, 2'b00});
    an          = blanked ? AN_OFF : ~(4'b0001 << sel_q);
    dp          = blanked ? 1'b1 : ~disp_dp_q[sel_q];
    pending     = pend_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux with REFRESH_DIV=4.
module tb_seg_scan_mux;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        pending;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  int unsigned checks;
  int unsigned failures;

  seg_scan_mux #(
    .REFRESH_DIV (4),
    .CNT_W       (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .blank_lz    (blank_lz),
    .pending     (pending),
    .digit       (digit),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench just after the edge where sel wrapped 3 -> 0 (sel=0, cnt=0).
  task automatic wait_frame(input string name);
    int unsigned n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL %s frame_start timeout: got %b want 1", name, frame_start);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an [5];
    int unsigned pulses;
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    checks += 5;
    if (digit !== 4'h0)     begin failures++; $display("FAIL reset_digit got %h want 0", digit); end
    if (an !== 4'b1110)     begin failures++; $display("FAIL reset_an got %b want 1110", an); end
    if (dp !== 1'b1)        begin failures++; $display("FAIL reset_dp got %b want 1", dp); end
    if (pending !== 1'b0)   begin failures++; $display("FAIL reset_pending got %b want 0", pending); end
    if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got %b want 0", frame_start); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (an !== exp_an[k]) begin
        failures++;
        $display("FAIL scan_an[%0d] got %b want %b", k, an, exp_an[k]);
      end
      repeat (4) cyc();
    end
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (frame_start === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL fs_rate got %0d pulses want 2 in 32 cycles", pulses);
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] exp_dig [4];
    logic       exp_dp  [4];
    logic [3:0] exp_an  [4];
    exp_dig = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wait_frame("lc_align");
    repeat (5) cyc();
    value = 16'h1234; dp_in = 4'b0100; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL lc_pending_set got %b want 1", pending); end
    repeat (9) cyc();
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL lc_pending_hold got %b want 1", pending); end
    wait_frame("lc_commit");
    checks++;
    if (pending !== 1'b0) begin failures++; $display("FAIL lc_pending_clr got %b want 0", pending); end
    for (int p = 0; p < 4; p++) begin
      checks += 3;
      if (digit !== exp_dig[p]) begin failures++; $display("FAIL lc_digit[%0d] got %h want %h", p, digit, exp_dig[p]); end
      if (an !== exp_an[p])     begin failures++; $display("FAIL lc_an[%0d] got %b want %b", p, an, exp_an[p]); end
      if (dp !== exp_dp[p])     begin failures++; $display("FAIL lc_dp[%0d] got %b want %b", p, dp, exp_dp[p]); end
      repeat (4) cyc();
    end
  endtask

  task automatic test_blank_lz();
    logic [3:0] exp_an  [4];
    logic [3:0] exp_dig [4];
    exp_an  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    exp_dig = '{4'h2, 4'h4, 4'h0, 4'h0};
    blank_lz = 1'b1;
    value = 16'h0042; dp_in = 4'b1100; load = 1'b1;
    cyc();
    load = 1'b0;
    wait_frame("blz_commit");
    for (int p = 0; p < 4; p++) begin
      checks += 3;
      if (an !== exp_an[p])      begin failures++; $display("FAIL blz_an[%0d] got %b want %b", p, an, exp_an[p]); end
      if (dp !== 1'b1)           begin failures++; $display("FAIL blz_dp[%0d] got %b want 1", p, dp); end
      if (p < 2 && digit !== exp_dig[p]) begin
        failures++; $display("FAIL blz_digit[%0d] got %h want %h", p, digit, exp_dig[p]);
      end
      repeat (4) cyc();
    end
    value = 16'h0000; dp_in = 4'b0000; load = 1'b1;
    cyc();
    load = 1'b0;
    wait_frame("blz0_commit");
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (p == 0) begin
        if (an !== 4'b1110 || digit !== 4'h0) begin
          failures++; $display("FAIL blz0_pos0 got an=%b digit=%h want an=1110 digit=0", an, digit);
        end
      end else if (an !== 4'b1111) begin
        failures++; $display("FAIL blz0_an[%0d] got %b want 1111", p, an);
      end
      repeat (4) cyc();
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_collision();
    wait_frame("col_align");
    repeat (2) cyc();
    value = 16'hAAAA; dp_in = 4'b0000; load = 1'b1;
    cyc();
    load = 1'b0;
    repeat (12) cyc();
    value = 16'h5555; load = 1'b1;
    cyc();
    load = 1'b0;
    checks += 2;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL col_fs got %b want 1", frame_start); end
    if (pending !== 1'b1)     begin failures++; $display("FAIL col_pending got %b want 1", pending); end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (digit !== 4'hA) begin failures++; $display("FAIL col_old[%0d] got %h want a", p, digit); end
      repeat (4) cyc();
    end
    checks += 2;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL col_fs2 got %b want 1", frame_start); end
    if (pending !== 1'b0)     begin failures++; $display("FAIL col_pending2 got %b want 0", pending); end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (digit !== 4'h5) begin failures++; $display("FAIL col_new[%0d] got %h want 5", p, digit); end
      repeat (4) cyc();
    end
  endtask

  task automatic test_reset_pending();
    int unsigned bad;
    wait_frame("rp_align");
    repeat (2) cyc();
    value = 16'hBEEF; dp_in = 4'b1111; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL rp_pending_set got %b want 1", pending); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks += 3;
    if (pending !== 1'b0)   begin failures++; $display("FAIL rp_pending got %b want 0", pending); end
    if (an !== 4'b1110)     begin failures++; $display("FAIL rp_an got %b want 1110", an); end
    if (digit !== 4'h0)     begin failures++; $display("FAIL rp_digit got %h want 0", digit); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (digit !== 4'h0 || pending !== 1'b0 || dp !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rp_no_beef got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int unsigned saw_one;
    wait_frame("b2b_align");
    cyc();
    value = 16'h1111; dp_in = 4'b0000; load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    value = 16'h2222; load = 1'b1;
    cyc();
    load = 1'b0;
    saw_one = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (digit === 4'h1) saw_one++;
    end
    wait_frame("b2b_commit");
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (digit !== 4'h2) begin failures++; $display("FAIL b2b_digit[%0d] got %h want 2", p, digit); end
      for (int i = 0; i < 4; i++) begin
        if (digit === 4'h1) saw_one++;
        cyc();
      end
    end
    checks++;
    if (saw_one != 0) begin failures++; $display("FAIL b2b_no_1111 got %0d cycles showing 1 want 0", saw_one); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    blank_lz = 1'b0;
    test_reset();
    test_load_commit();
    test_blank_lz();
    test_collision();
    test_reset_pending();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
